mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the RV32IM pipeline, directly downstream of EX.
- Holds the EX/MEM pipeline register and drives a word-wide data-memory port with a req/ready handshake.
- Generates byte lanes, store data and sign/zero-extended load data, and stalls upstream stages while an access is outstanding.
- Produces the registered MEM/WB outputs.

Parameters:
- TIMEOUT_CYCLES, 16, maximum DMEM_REQ cycles before an access is abandoned with a fault (≥2).
- CNT_W, 5, width of the timeout counter (≥ clog2(TIMEOUT_CYCLES)+1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-low reset.
- EX_JAL_SELECTED  in  32  ALU result or PC+4; used as address for loads/stores.
- EX_READ_DATA2  in  32  store data.
- EX_RD  in  5  destination register.
- EX_FUNC3  in  3  access size/sign.
- EX_WRITE_ENABLE, EX_DATA_MEM_SELECT, EX_MEM_WRITE, EX_MEM_READ  in  1 each  control from EX.
- DMEM_RDATA  in  32  memory read word.
- DMEM_READY  in  1  access complete this cycle.
- DMEM_REQ  out  1  access request.
- DMEM_WE  out  1  1 = store.
- DMEM_ADDR  out  32  word-aligned address {addr[31:2],2'b00}.
- DMEM_WDATA  out  32  lane-replicated store data.
- DMEM_BYTE_EN  out  4  byte enables.
- MEM_STALL  out  1  freeze PC, IF/ID, ID/EX and EX/MEM register this cycle.
- MEM_RESULT  out  32  WB data.
- MEM_RD  out  5  WB destination.
- MEM_WRITE_ENABLE  out  1  WB register write.
- MEM_FAULT  out  1  misaligned/illegal/timeout on the instruction now in WB.

Behaviour:
- Reset (RST=0 at edge):
  - EX/MEM register cleared (nop); state IDLE; counter 0.
  - MEM_RESULT/MEM_RD/MEM_WRITE_ENABLE/MEM_FAULT = 0.
  - DMEM_REQ = 0 from the next cycle. Any outstanding access is abandoned; memory must tolerate a dropped request.
- EX/MEM register (R) captures all EX_* inputs on each edge where MEM_STALL=0.
- mem_op = R.MEM_READ | R.MEM_WRITE.
- Misaligned/illegal:
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - load func3 ∈ {3,6,7};
  - store func3 ∉ {0,1,2}.
- FSM states: IDLE, ACCESS.
  - R holds an aligned mem_op → ACCESS. DMEM_REQ=1 and DMEM_WE=R.MEM_WRITE held stable until completion; cnt increments every ACCESS cycle starting at 0.
  - Completion occurs at the edge where DMEM_READY=1 or cnt=TIMEOUT_CYCLES-1. Next state is IDLE, or ACCESS again if the newly captured R is an aligned mem_op (back-to-back, no bubble). cnt resets to 0.
  - MEM_STALL = ACCESS & ~DMEM_READY & (cnt≠TIMEOUT_CYCLES-1).
  - Zero-wait memory (READY in first cycle) → no stall, one access per cycle.
- Non-mem or misaligned: no request and no stall.
- Byte lanes (off = addr[1:0]):
  - SB: BYTE_EN=0001<<off, WDATA={4{data[7:0]}}.
  - SH: BYTE_EN=0011<<off, WDATA={2{data[15:0]}}.
  - SW: BYTE_EN=1111, WDATA=data.
  - Loads: BYTE_EN per size; WDATA=0.
- Load extract: shifted = RDATA >> (8·off).
  - LB/LH sign-extend bits 7/15.
  - LBU/LHU zero-extend.
  - LW takes the word.
- MEM/WB register update on each edge where MEM_STALL=0:
  - MEM_RESULT = R.DATA_MEM_SELECT ? load_data : R.JAL_SELECTED.
  - MEM_RD = R.RD.
  - MEM_WRITE_ENABLE = R.WRITE_ENABLE & (R.RD≠0) & ~fault.
  - MEM_FAULT = misaligned | timeout.
  - A fault suppresses the memory access (misaligned case) and the register write.
- Latency: EX→WB outputs 1 cycle after R capture, plus stall cycles.

Decomposition:
- Shared package mem_pkg:
  - func3 constants (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5);
  - FSM state encoding (IDLE, ACCESS).
- One combinational sub-module, mem_lane_align, covering:
  - byte-enable generation;
  - store data replication;
  - load extraction and extension;
  - misalignment detection.
- The FSM, counter and pipeline registers stay in mem_stage.

Test Plan:
- ALU op: JAL_SELECTED=0x00001234, RD=5, WE=1, no mem → next cycle MEM_RESULT=0x00001234, MEM_RD=5, MEM_WRITE_ENABLE=1, DMEM_REQ=0, MEM_STALL=0.
- SB addr 0x00001003, data 0xAABBCCDD, READY=1 in first cycle → DMEM_ADDR=0x00001000, BYTE_EN=1000, WDATA=0xDDDDDDDD, WE=1, no stall.
- LH addr 0x00002002, RDATA=0x80017F00, READY after 3 wait cycles → MEM_STALL high 3 cycles, MEM_RESULT=0xFFFF8001; same with LHU → 0x00008001; LBU at off=1 → 0x0000007F.
- LW addr 0x00003001, RD=7, WE=1 → no DMEM_REQ, no stall, MEM_FAULT=1, MEM_WRITE_ENABLE=0.
- TIMEOUT_CYCLES=16, READY held 0 → DMEM_REQ high 16 cycles, MEM_STALL high 15 cycles, then MEM_FAULT=1, MEM_WRITE_ENABLE=0, state IDLE.
- RST=0 during ACCESS at cnt=4 → next cycle DMEM_REQ=0, MEM_STALL=0, all MEM_* outputs 0; a later aligned LW completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants, types and alignment check for the memory stage
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef struct packed {
        logic [31:0] jal_selected;
        logic [31:0] read_data2;
        logic [4:0]  rd;
        logic [2:0]  func3;
        logic        write_enable;
        logic        data_mem_select;
        logic        mem_write;
        logic        mem_read;
    } ex_mem_t;

    // Shared by the lane aligner and the FSM look-ahead on the EX inputs.
    function automatic logic access_bad(input logic [1:0] off, input logic [2:0] func3,
                                        input logic mem_read, input logic mem_write);
        logic bad;
        bad = 1'b0;
        if (mem_read && (func3 == 3'd3 || func3 == 3'd6 || func3 == 3'd7))
            bad = 1'b1;
        if (mem_write && func3 > F3_W)
            bad = 1'b1;
        if (func3[1:0] == 2'd1 && off[0])
            bad = 1'b1;
        if (func3[1:0] == 2'd2 && off != 2'd0)
            bad = 1'b1;
        return (mem_read | mem_write) & bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte lanes, store replication, load extraction and misalignment
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  func3,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [1:0]  off;
    logic [31:0] shifted;

    assign off        = addr[1:0];
    assign shifted    = rdata >> {off, 3'b000};
    assign misaligned = access_bad(off, func3, mem_read, mem_write);

    always_comb begin
        byte_en = 4'b1111;
        wdata   = store_data;
        case (func3[1:0])
            2'd0: begin
                byte_en = 4'b0001 << off;
                wdata   = {4{store_data[7:0]}};
            end
            2'd1: begin
                byte_en = 4'b0011 << off;
                wdata   = {2{store_data[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wdata   = store_data;
            end
        endcase
        if (!mem_write)
            wdata = 32'd0;
    end

    always_comb begin
        load_data = shifted;
        case (func3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {24'd0, shifted[7:0]};
            F3_HU:   load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32IM memory stage: EX/MEM register, dmem handshake FSM, MEM/WB register
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] EX_JAL_SELECTED,
    input  logic [31:0] EX_READ_DATA2,
    input  logic [4:0]  EX_RD,
    input  logic [2:0]  EX_FUNC3,
    input  logic        EX_WRITE_ENABLE,
    input  logic        EX_DATA_MEM_SELECT,
    input  logic        EX_MEM_WRITE,
    input  logic        EX_MEM_READ,
    input  logic [31:0] DMEM_RDATA,
    input  logic        DMEM_READY,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [31:0] DMEM_WDATA,
    output logic [3:0]  DMEM_BYTE_EN,
    output logic        MEM_STALL,
    output logic [31:0] MEM_RESULT,
    output logic [4:0]  MEM_RD,
    output logic        MEM_WRITE_ENABLE,
    output logic        MEM_FAULT
);

    ex_mem_t        r;
    ex_mem_t        ex_in;
    state_t         state;
    state_t         next_state;
    logic [CNT_W-1:0] cnt;
    logic           in_access;
    logic           last_cycle;
    logic           timeout;
    logic           ex_go;
    logic           misaligned;
    logic           fault;
    logic [31:0]    load_data;

    always_comb begin
        ex_in                 = '0;
        ex_in.jal_selected    = EX_JAL_SELECTED;
        ex_in.read_data2      = EX_READ_DATA2;
        ex_in.rd              = EX_RD;
        ex_in.func3           = EX_FUNC3;
        ex_in.write_enable    = EX_WRITE_ENABLE;
        ex_in.data_mem_select = EX_DATA_MEM_SELECT;
        ex_in.mem_write       = EX_MEM_WRITE;
        ex_in.mem_read        = EX_MEM_READ;
    end

    mem_lane_align u_align (
        .addr       (r.jal_selected),
        .func3      (r.func3),
        .store_data (r.read_data2),
        .rdata      (DMEM_RDATA),
        .mem_read   (r.mem_read),
        .mem_write  (r.mem_write),
        .byte_en    (DMEM_BYTE_EN),
        .wdata      (DMEM_WDATA),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    assign in_access  = (state == ACCESS);
    assign last_cycle = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign MEM_STALL  = in_access & ~DMEM_READY & ~last_cycle;
    assign timeout    = in_access & ~DMEM_READY & last_cycle;
    assign fault      = misaligned | timeout;
    // ACCESS is entered as R captures an aligned mem op, so the request goes out in R's first cycle.
    assign ex_go      = (EX_MEM_READ | EX_MEM_WRITE)
                      & ~access_bad(EX_JAL_SELECTED[1:0], EX_FUNC3, EX_MEM_READ, EX_MEM_WRITE);

    assign DMEM_REQ  = in_access;
    assign DMEM_WE   = in_access & r.mem_write;
    assign DMEM_ADDR = {r.jal_selected[31:2], 2'b00};

    always_comb begin
        next_state = state;
        if (!MEM_STALL)
            next_state = ex_go ? ACCESS : IDLE;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= '0;
            r     <= '0;
        end else begin
            state <= next_state;
            cnt   <= MEM_STALL ? cnt + 1'b1 : '0;
            if (!MEM_STALL)
                r <= ex_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            MEM_RESULT       <= '0;
            MEM_RD           <= '0;
            MEM_WRITE_ENABLE <= 1'b0;
            MEM_FAULT        <= 1'b0;
        end else if (!MEM_STALL) begin
            MEM_RESULT       <= r.data_mem_select ? load_data : r.jal_selected;
            MEM_RD           <= r.rd;
            MEM_WRITE_ENABLE <= r.write_enable & (r.rd != 5'd0) & ~fault;
            MEM_FAULT        <= fault;
        end
    end

endmodule
